nv_ram_fifo_ctrl_512x32: RTL
============================

NV_RAM_FIFO_CTRL_512X32 -- requirements
Module: nv_ram_fifo_ctrl_512x32

Interface
REQ-001 SHALL have parameter AW, default 9, RAM address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter DEPTH, default 512, entries (2^AW).
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk  in  1  sole clock; all state on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port wr_pvld  in  1  write-side valid.
REQ-008 SHALL have port wr_prdy  out  1  write-side ready.
REQ-009 SHALL have port wr_pd  in  DW  write payload.
REQ-010 SHALL have port rd_pvld  out  1  read-side valid.
REQ-011 SHALL have port rd_prdy  in  1  read-side ready.
REQ-012 SHALL have port rd_pd  out  DW  read payload.
REQ-013 SHALL have port ram_wa  out  AW  RAM write address.
REQ-014 SHALL have port ram_we  out  1  RAM write enable.
REQ-015 SHALL have port ram_di  out  DW  RAM write data.
REQ-016 SHALL have port ram_ra  out  AW  RAM read address.
REQ-017 SHALL have port ram_re  out  1  RAM read enable; RAM latches ra on re, and its dout shows M[latched ra] until the next re.
REQ-018 SHALL have port ram_dout  in  DW  RAM read data.
REQ-019 SHALL have port ram_pwrbus_pd  out  32  RAM power-down bus, constant 0.
REQ-020 SHALL have port fifo_count  out  AW+1  occupancy, 0..DEPTH.
REQ-021 SHALL have port hwm_clr  in  1  high-water-mark clear.
REQ-022 SHALL have port hwm_count  out  AW+1  high-water mark.

Function
REQ-023 SHALL accept a write when wr_pvld & wr_prdy; wr_prdy = (fifo_count != DEPTH), from registers only.
REQ-024 SHALL drive ram_we = wr_pvld & wr_prdy, ram_wa = wptr and ram_di = wr_pd combinationally; wptr increments mod DEPTH on accept (511 -> 0).
REQ-025 SHALL keep unf, the count of entries committed to RAM but not yet fetched; a write increments unf at its accepting edge.
REQ-026 SHALL drive ram_re = (unf != 0) & (!rd_pvld | rd_prdy), with ram_ra = rptr; rptr increments mod DEPTH on ram_re.
REQ-027 SHALL update rd_pvld next = ram_re ? 1 : (rd_prdy ? 0 : rd_pvld).
REQ-028 SHALL drive rd_pd = ram_dout directly; data stays stable while rd_pvld & !rd_prdy because no re is issued.
REQ-029 SHALL pop on rd_pvld & rd_prdy; fifo_count +1 on accepted write, -1 on pop, unchanged on both or neither.
REQ-030 SHALL count the presented entry in fifo_count, so its RAM slot is never overwritten while displayed.
REQ-031 SHALL give write-accept-to-rd_pvld latency of 2 cycles into an empty FIFO: the write edge, then the re edge.
REQ-032 SHALL sustain one pop per cycle when unf > 0 and rd_prdy is held high.
REQ-033 SHALL never read and write the same address in one cycle; this follows from REQ-025.
REQ-034 SHALL leave full-at-DEPTH with a pop; wr_prdy rises on the following cycle.

Reset
REQ-035 SHALL on rst clear wptr, rptr, unf, fifo_count, rd_pvld and hwm_count to 0; wr_prdy = 1 and ram_re = 0 immediately.
REQ-036 SHALL on reset mid-operation discard all contents; RAM is not cleared and rd_pd is don't-care while rd_pvld = 0.

Configuration
REQ-037 SHALL, with NV_RAM_FIFO_HWM_EN defined, register hwm_count = max(hwm_count, fifo_count) each cycle, with hwm_clr loading the current fifo_count.
REQ-038 SHALL, without NV_RAM_FIFO_HWM_EN, tie hwm_count to 0, ignore hwm_clr, and keep all ports present.

Structure
REQ-039 SHALL place AW, DW and DEPTH constants in shared package nv_ram_fifo_pkg.
REQ-040 SHALL contain no sub-module; the 512x32 RAM is instantiated beside this block by the parent.

Verification
REQ-041 SHALL cover: reset, then write 0xA5A5_0001 at cycle 0 -> rd_pvld = 1 at cycle 2 with rd_pd = 0xA5A5_0001.
REQ-042 SHALL cover: 512 writes with rd_prdy = 0 -> fifo_count = 512, wr_prdy = 0; a 513th wr_pvld is not accepted.
REQ-043 SHALL cover: full FIFO, then rd_prdy = 1 continuously -> 512 pops, one per cycle, in order; wr_prdy = 1 the cycle after the first pop.
REQ-044 SHALL cover: 600 writes of incrementing data interleaved with random rd_prdy -> pointers wrap 511 -> 0 and output order is intact.
REQ-045 SHALL cover: rd_prdy = 0 for 10 cycles with rd_pvld = 1 while writes continue -> rd_pd unchanged and ram_re = 0.
REQ-046 SHALL cover, with NV_RAM_FIFO_HWM_EN: fill to 300, drain to 5 -> hwm_count = 300; pulse hwm_clr -> hwm_count = 5.

Source files
------------

// File: rtl/nv_ram_fifo_pkg.sv
// ============================================================================
// Module      : nv_ram_fifo_pkg
// Description : Shared geometry constants for the 512x32 RAM-backed FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nv_ram_fifo_pkg;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

endpackage : nv_ram_fifo_pkg

`default_nettype wire

// File: rtl/nv_ram_fifo_ctrl_512x32.sv
// ============================================================================
// Module      : nv_ram_fifo_ctrl_512x32
// Description : Valid/ready FIFO controller driving an external 512x32 RAM
//               with a registered read stage. The optional high-water-mark
//               tracker is enabled by defining NV_RAM_FIFO_HWM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nv_ram_fifo_ctrl_512x32 #(
    parameter int AW    = nv_ram_fifo_pkg::AW,
    parameter int DW    = nv_ram_fifo_pkg::DW,
    parameter int DEPTH = nv_ram_fifo_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    output logic [31:0]   ram_pwrbus_pd,
    output logic [AW:0]   fifo_count,
    input  logic          hwm_clr,
    output logic [AW:0]   hwm_count
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   unf_q,  unf_d;
    logic [AW:0]   cnt_q,  cnt_d;
    logic          rd_pvld_q, rd_pvld_d;
    logic          wr_acc;
    logic          rd_fetch;
    logic          rd_pop;

    assign wr_prdy  = (cnt_q != FULL_CNT);
    assign wr_acc   = wr_pvld & wr_prdy;
    // A fetch only targets entries already committed, so ra never equals wa.
    assign rd_fetch = (unf_q != '0) & (~rd_pvld_q | rd_prdy);
    assign rd_pop   = rd_pvld_q & rd_prdy;

    assign ram_we        = wr_acc;
    assign ram_wa        = wptr_q;
    assign ram_di        = wr_pd;
    assign ram_re        = rd_fetch;
    assign ram_ra        = rptr_q;
    assign ram_pwrbus_pd = 32'd0;
    assign rd_pvld       = rd_pvld_q;
    assign rd_pd         = ram_dout;
    assign fifo_count    = cnt_q;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        unf_d     = unf_q;
        cnt_d     = cnt_q;
        rd_pvld_d = rd_pvld_q;

        if (wr_acc) begin
            wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
        end
        if (rd_fetch) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
        end

        case ({wr_acc, rd_fetch})
            2'b10:   unf_d = unf_q + 1'b1;
            2'b01:   unf_d = unf_q - 1'b1;
            default: unf_d = unf_q;
        endcase

        // The displayed entry stays counted until popped, protecting its slot.
        case ({wr_acc, rd_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (rd_fetch) begin
            rd_pvld_d = 1'b1;
        end else if (rd_prdy) begin
            rd_pvld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            unf_q     <= '0;
            cnt_q     <= '0;
            rd_pvld_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            unf_q     <= unf_d;
            cnt_q     <= cnt_d;
            rd_pvld_q <= rd_pvld_d;
        end
    end

`ifdef NV_RAM_FIFO_HWM_EN
    logic [AW:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr) begin
            hwm_d = cnt_q;
        end else if (cnt_q > hwm_q) begin
            hwm_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_count = hwm_q;
`else
    logic hwm_clr_unused;

    assign hwm_clr_unused = hwm_clr;
    assign hwm_count      = '0;
`endif

endmodule : nv_ram_fifo_ctrl_512x32

`default_nettype wire
